traffic_sensor_queue: RTL

- Street-side counterpart of the two-street traffic-light controller. It consumes the controller's light outputs la and lb and produces its sensor inputs ta and tb.
- Keeps a per-street queue of waiting cars. Arrivals come from detector pulses; departures happen at a fixed rate while that street's light is green.
- Raises ta/tb while the matching queue is non-empty.
- Also checks light safety: both streets must never be non-red at once, and no illegal light code may appear.
- Used both as a synthesizable sensor front end and as a closed-loop stimulus model in controller benches.

---
 rtl/traffic_sensor_queue.sv | 101 ++++++++++
 1 files changed

// File: rtl/traffic_sensor_queue.sv
// Street-side sensor model for the two-street traffic-light controller: per-street car
// queues that fill from detector pulses, drain while green, and a sticky light-safety flag.
module traffic_sensor_queue #(
   parameter int QW         = 4,
   parameter int DEPART_CYC = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          car_a,
   input  logic          car_b,
   input  logic [1:0]    la,
   input  logic [1:0]    lb,
   output logic          ta,
   output logic          tb,
   output logic [QW-1:0] qa,
   output logic [QW-1:0] qb,
   output logic          ovf_a,
   output logic          ovf_b,
   output logic          viol
);

   localparam int             DTW     = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;
   localparam logic [QW-1:0]  QMAX    = '1;
   localparam logic [DTW-1:0] DT_LAST = DTW'(DEPART_CYC - 1);
   localparam logic [1:0]     GREEN   = 2'b00;
   localparam logic [1:0]     RED     = 2'b10;
   localparam logic [1:0]     ILLEGAL = 2'b11;

   logic [DTW-1:0] dt_a;
   logic [DTW-1:0] dt_b;
   logic [DTW-1:0] dt_a_nxt;
   logic [DTW-1:0] dt_b_nxt;
   logic           run_a;
   logic           run_b;
   logic           dep_a;
   logic           dep_b;
   logic [QW-1:0]  qa_nxt;
   logic [QW-1:0]  qb_nxt;
   logic           ovf_a_hit;
   logic           ovf_b_hit;
   logic           unsafe;

   // An arrival and a departure in the same cycle cancel, so a full queue only overflows on a pure arrival.
   function automatic logic [QW-1:0] queue_next(input logic [QW-1:0] q,
                                                input logic car,
                                                input logic dep);
      if (car && !dep && q != QMAX) return q + QW'(1);
      if (!car && dep)              return q - QW'(1);
      return q;
   endfunction

   function automatic logic queue_drop(input logic [QW-1:0] q,
                                       input logic car,
                                       input logic dep);
      return car && !dep && (q == QMAX);
   endfunction

   function automatic logic [DTW-1:0] timer_next(input logic [DTW-1:0] dt,
                                                 input logic run);
      if (!run || dt == DT_LAST) return '0;
      return dt + DTW'(1);
   endfunction

   always_comb begin
      run_a     = (la == GREEN) && (qa != '0);
      run_b     = (lb == GREEN) && (qb != '0);
      dep_a     = run_a && (dt_a == DT_LAST);
      dep_b     = run_b && (dt_b == DT_LAST);
      dt_a_nxt  = timer_next(dt_a, run_a);
      dt_b_nxt  = timer_next(dt_b, run_b);
      qa_nxt    = queue_next(qa, car_a, dep_a);
      qb_nxt    = queue_next(qb, car_b, dep_b);
      ovf_a_hit = queue_drop(qa, car_a, dep_a);
      ovf_b_hit = queue_drop(qb, car_b, dep_b);
      unsafe    = (la == ILLEGAL) || (lb == ILLEGAL) || ((la != RED) && (lb != RED));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         qa    <= '0;
         qb    <= '0;
         dt_a  <= '0;
         dt_b  <= '0;
         ovf_a <= 1'b0;
         ovf_b <= 1'b0;
         viol  <= 1'b0;
      end else begin
         qa    <= qa_nxt;
         qb    <= qb_nxt;
         dt_a  <= dt_a_nxt;
         dt_b  <= dt_b_nxt;
         ovf_a <= ovf_a | ovf_a_hit;
         ovf_b <= ovf_b | ovf_b_hit;
         viol  <= viol | unsafe;
      end
   end

   assign ta = (qa != '0);
   assign tb = (qb != '0);

endmodule
